// File: rtl/prim_ram_port_arb.sv
// Round-robin sequencer sharing one RAM primitive port between NumReq requesters.
// Define PRIM_RAM_PORT_ARB_INIT_EN to zero the whole array after every reset.
module prim_ram_port_arb #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width  = 32,
  parameter int unsigned Depth  = 128,
  localparam int unsigned Aw    = $clog2(Depth),
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq-1:0]       write_i,
  input  logic [NumReq*Aw-1:0]    addr_i,
  input  logic [NumReq*Width-1:0] wdata_i,
  input  logic [NumReq*Width-1:0] wmask_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       rvalid_o,
  output logic [Width-1:0]        rdata_o,
  output logic                    init_done_o,
  output logic                    ram_req_o,
  output logic                    ram_write_o,
  output logic [Aw-1:0]           ram_addr_o,
  output logic [Width-1:0]        ram_wdata_o,
  output logic [Width-1:0]        ram_wmask_o,
  input  logic [Width-1:0]        ram_rdata_i
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  logic            active_q;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_pend_q, rd_pend_d;
  logic [IdxW-1:0] sel, cand;
  logic            found;
  int unsigned     arb_k;

`ifdef PRIM_RAM_PORT_ARB_INIT_EN
  typedef enum logic {StInit, StRun} state_e;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e        state_q, state_d;
  logic [Aw-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_done_o = (state_q == StRun);
`else
  assign init_done_o = 1'b1;
`endif

  // First asserted request at or after ptr, wrapping modulo NumReq.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    arb_k = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      arb_k = 32'(ptr_q) + i;
      if (arb_k >= NumReq) arb_k = arb_k - NumReq;
      cand = IdxW'(arb_k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    gnt_o       = '0;
    ptr_d       = ptr_q;
    rd_pend_d   = 1'b0;
    rd_idx_d    = rd_idx_q;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
`ifdef PRIM_RAM_PORT_ARB_INIT_EN
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
`endif
    if (active_q) begin
`ifdef PRIM_RAM_PORT_ARB_INIT_EN
      if (state_q == StInit) begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = init_cnt_q;
        ram_wmask_o = '1;
        if (init_cnt_q == LastAddr) state_d = StRun;
        else init_cnt_d = init_cnt_q + 1'b1;
      end else
`endif
      if (found) begin
        gnt_o[sel]  = 1'b1;
        ram_req_o   = 1'b1;
        ram_write_o = write_i[sel];
        ram_addr_o  = addr_i[int'(sel)*Aw +: Aw];
        ram_wdata_o = wdata_i[int'(sel)*Width +: Width];
        ram_wmask_o = wmask_i[int'(sel)*Width +: Width];
        rd_pend_d   = !write_i[sel];
        rd_idx_d    = sel;
        ptr_d       = (sel == LastIdx) ? '0 : sel + 1'b1;
      end
    end
  end

  // active_q keeps grants and RAM requests off until the first edge out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q  <= 1'b0;
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      active_q  <= 1'b1;
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (rd_pend_q) rvalid_o[rd_idx_q] = 1'b1;
  end

  assign rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_prim_ram_port_arb.sv
// Scoreboard bench for prim_ram_port_arb with a behavioural RAM port.
// Expectations follow PRIM_RAM_PORT_ARB_INIT_EN when it is defined.
module tb_prim_ram_port_arb;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = $clog2(D);
`ifdef PRIM_RAM_PORT_ARB_INIT_EN
  localparam int INIT_CYC = D;
`else
  localparam int INIT_CYC = 0;
`endif

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } rd_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_i, write_i;
  logic [NR*AW-1:0] addr_i;
  logic [NR*W-1:0]  wdata_i, wmask_i;
  logic [NR-1:0]    gnt_o, rvalid_o;
  logic [W-1:0]     rdata_o;
  logic             init_done_o;
  logic             ram_req, ram_write;
  logic [AW-1:0]    ram_addr;
  logic [W-1:0]     ram_wdata, ram_wmask, ram_rdata;

  logic [NR-1:0] req_s, wr_s;
  logic [AW-1:0] addr_s [NR];
  logic [W-1:0]  wdata_s [NR];
  logic [W-1:0]  wmask_s [NR];
  logic          hold;
  logic          fill;

  logic [W-1:0]  ram [D];
  logic [W-1:0]  mem_m [D];
  rd_t           sbq [$];
  int            ptr_m;
  logic          in_init_m;
  logic [AW-1:0] sweep_m;
  int            lowcnt;
  int            n_chk = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  prim_ram_port_arb #(
    .NumReq(NR),
    .Width (W),
    .Depth (D)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req_i),
    .write_i    (write_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .wmask_i    (wmask_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .init_done_o(init_done_o),
    .ram_req_o  (ram_req),
    .ram_write_o(ram_write),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_wmask_o(ram_wmask),
    .ram_rdata_i(ram_rdata)
  );

  function automatic logic [W-1:0] junk(int a);
    return 32'hA5A5_0000 ^ W'(a * 32'h0001_0203);
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < D; i++) ram[i] <= junk(i);
    end else if (ram_req) begin
      if (ram_write)
        ram[ram_addr] <= (ram[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else
        ram_rdata <= ram[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic drive();
    req_i   = req_s;
    write_i = wr_s;
    for (int j = 0; j < NR; j++) begin
      addr_i[j*AW +: AW] = addr_s[j];
      wdata_i[j*W +: W]  = wdata_s[j];
      wmask_i[j*W +: W]  = wmask_s[j];
    end
  endtask

  task automatic stage(input int k, input logic wr, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m);
    req_s[k]   = 1'b1;
    wr_s[k]    = wr;
    addr_s[k]  = a;
    wdata_s[k] = d;
    wmask_s[k] = m;
  endtask

  task automatic tick();
    int            k;
    rd_t           e;
    logic [NR-1:0] eg;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      eg = NR'(1) << e.idx;
      chk("rvalid", 64'(rvalid_o), 64'(eg));
      chk("rdata", 64'(rdata_o), 64'(e.data));
    end else begin
      chk("rvalid_idle", 64'(rvalid_o), 64'(0));
    end
    drive();
    #1;
    if (!init_done_o) lowcnt++;
    chk("init_done", 64'(init_done_o), 64'(!in_init_m));
    if (in_init_m) begin
      chk("init_gnt", 64'(gnt_o), 64'(0));
      chk("init_cmd", 64'({ram_req, ram_write, ram_addr}), 64'({2'b11, sweep_m}));
      chk("init_data", 64'({ram_wdata, ram_wmask}), {32'h0, 32'hFFFF_FFFF});
      mem_m[sweep_m] = '0;
      if (sweep_m == AW'(D - 1)) in_init_m = 1'b0;
      else sweep_m++;
    end else begin
      k = -1;
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (ptr_m + i) % NR;
        if (k < 0 && req_s[c]) k = c;
      end
      eg = (k >= 0) ? (NR'(1) << k) : '0;
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("ram_req", 64'(ram_req), 64'(k >= 0));
      if (k >= 0) begin
        chk("ram_cmd", 64'({ram_write, ram_addr}), 64'({wr_s[k], addr_s[k]}));
        if (wr_s[k]) begin
          chk("ram_wdata", 64'(ram_wdata), 64'(wdata_s[k]));
          chk("ram_wmask", 64'(ram_wmask), 64'(wmask_s[k]));
          mem_m[addr_s[k]] = (mem_m[addr_s[k]] & ~wmask_s[k])
                           | (wdata_s[k] & wmask_s[k]);
        end else begin
          sbq.push_back('{k, mem_m[addr_s[k]]});
        end
        ptr_m = (k + 1) % NR;
      end
    end
    if (!hold) req_s &= ~gnt_o;
  endtask

  // Called just after a negedge; release lands before the next posedge.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sbq.delete();
    drive();
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_ram_req", 64'(ram_req), 64'(0));
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("rst_done", 64'(init_done_o), 64'(INIT_CYC == 0));
    repeat (n) @(negedge clk);
    #1;
    rst_n     = 1'b1;
    ptr_m     = 0;
    in_init_m = (INIT_CYC != 0);
    sweep_m   = '0;
    lowcnt    = 0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < D + 8; i++) begin
      tick();
      if (init_done_o) break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && req_s != '0; i++) tick();
    chk("drain", 64'(req_s), 64'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    fill  = 1'b1;
    hold  = 1'b0;
    req_s = '0;
    wr_s  = '0;
    for (int j = 0; j < NR; j++) begin
      addr_s[j]  = '0;
      wdata_s[j] = '0;
      wmask_s[j] = '0;
    end
    for (int i = 0; i < D; i++) mem_m[i] = junk(i);
    drive();
    @(negedge clk);
    fill = 1'b0;

    // Requests pending across reset release and the sweep
    stage(0, 1'b0, AW'(3), '0, '0);
    stage(3, 1'b1, AW'(7), 32'h1234_5678, 32'h0000_FFFF);
    do_reset(2);
    wait_init();
    chk("init_len", 64'(lowcnt), 64'(INIT_CYC));
    drain();

    stage(0, 1'b0, AW'(0), '0, '0);
    stage(1, 1'b0, AW'(5), '0, '0);
    stage(2, 1'b0, AW'(64), '0, '0);
    stage(3, 1'b0, AW'(127), '0, '0);
    drain();

    // All four held: rotating grants, one read response per cycle
    hold = 1'b1;
    for (int k = 0; k < NR; k++) stage(k, 1'b0, AW'(10 + k), '0, '0);
    repeat (9) tick();
    hold = 1'b0;
    req_s = '0;
    tick();

    stage(2, 1'b1, AW'(5), 32'hDEAD_BEEF, 32'hFFFF_0000);
    tick();
    stage(1, 1'b0, AW'(5), '0, '0);
    tick();
    tick();

    // ptr is 3 after req 2; lone req 1 wins, then ptr is 2
    stage(2, 1'b1, AW'(9), 32'h0000_0055, 32'hFFFF_FFFF);
    drain();
    stage(1, 1'b0, AW'(9), '0, '0);
    tick();
    chk("ptr_lone", 64'(gnt_o), 64'(4'b0010));
    for (int k = 0; k < NR; k++) stage(k, 1'b0, AW'(20 + k), '0, '0);
    tick();
    chk("ptr_next", 64'(gnt_o), 64'(4'b0100));
    drain();

    // Reset in the middle of a sweep restarts it from 0
    do_reset(1);
    repeat (40) tick();
    do_reset(0);
    wait_init();
    chk("reinit_len", 64'(lowcnt), 64'(INIT_CYC));
    tick();

    // Reset pulse between a read grant and its response
    stage(0, 1'b0, AW'(9), '0, '0);
    tick();
    do_reset(0);
    tick();
    chk("pulse_rvalid", 64'(rvalid_o), 64'(0));
    wait_init();
    stage(3, 1'b0, AW'(9), '0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prim_ram_port_arb.md
# prim_ram_port_arb

Single-port sequencer and round-robin arbiter that shares one port of the generic dual-port RAM primitive between `NumReq` requesters. When enabled, it also zero-initialises the whole array after every reset before any requester is served. One instance sits in front of each RAM port that needs to be shared. It drives the port's req/write/addr/wdata/wmask and routes read data back to the requester that issued the read.

## Interface
- `NumReq`, 4: number of requesters; must be ≥2.
- `Width`, 32: data width in bits; matches the RAM.
- `Depth`, 128: RAM word count; need not be a power of two.
- `Aw`, `$clog2(Depth)`: localparam, address width.
- `IdxW`, `$clog2(NumReq)`: localparam, requester index width.

Ports: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock, shared with the RAM port clock.
- `rst_ni` in 1: async active-low reset.
- `req_i` in NumReq: request per requester.
- `write_i` in NumReq: 1 = write, 0 = read.
- `addr_i` in NumReq*Aw: packed addresses; requester k occupies `[k*Aw +: Aw]`.
- `wdata_i` in NumReq*Width: packed write data.
- `wmask_i` in NumReq*Width: packed full-bit write masks.
- `gnt_o` out NumReq: one-hot grant; combinational from `req_i` and state.
- `rvalid_o` out NumReq: read data valid for requester k.
- `rdata_o` out Width: read data, shared by all requesters and qualified by `rvalid_o`.
- `init_done_o` out 1: array initialised and arbitration active.
- `ram_req_o`, `ram_write_o` out 1: drive the RAM port.
- `ram_addr_o` out Aw: drives the RAM port.
- `ram_wdata_o`, `ram_wmask_o` out Width: drive the RAM port.
- `ram_rdata_i` in Width: RAM port read data.

## Operation
- States:
  - INIT: sweep. Active only with the macro.
  - RUN: arbitrate.
- INIT behaviour:
  - Each cycle drives `ram_req_o`=1, `ram_write_o`=1, `ram_wdata_o`=0, `ram_wmask_o`=all ones, `ram_addr_o`=`init_cnt`.
  - `init_cnt` increments from 0.
  - At `init_cnt`==Depth-1 the state moves to RUN on the next edge. No wrap and no write beyond Depth-1.
  - `gnt_o`=0 throughout; requests are held off, not dropped.
- RUN arbitration:
  - Round-robin pointer `ptr` (IdxW bits).
  - Grant goes to the first asserted `req_i[k]` searching k = ptr, ptr+1, … modulo NumReq.
  - At most one grant per cycle. A granted request is forwarded to the RAM the same cycle.
  - On a grant to k, `ptr` <= (k+1) mod NumReq. With no request, `ptr` holds and `ram_req_o`=0.
- Handshake:
  - Requester holds `req_i` and its payload stable until it sees `gnt_o`.
  - The transfer completes in the cycle where `req_i` & `gnt_o` are both high.
- Reads:
  - A granted read (`write_i`[k]=0) sets a registered `rd_pend` and `rd_idx`=k.
  - Next cycle: `rvalid_o[rd_idx]`=1 and `rdata_o`=`ram_rdata_i` (pass-through).
- Writes return no response.
- Back-to-back reads from different requesters each get their own `rvalid` in consecutive cycles.
- `rdata_o` is don't-care when no `rvalid_o` bit is set.

## Timing
- Reset values:
  - State = INIT with the macro, RUN without.
  - `init_cnt`=0, `ptr`=0, `rd_pend`=0.
  - `rvalid_o`=0.
  - `init_done_o`=0 with the macro, 1 without.
  - `gnt_o`=0 and `ram_req_o`=0 while `rst_ni` is low: combinational outputs are gated by a reset-synchronous `active` flop.
- Grant latency: 0 cycles from `req_i` in RUN.
- Read data latency: 1 cycle after grant.
- Throughput: 1 access per cycle.
- INIT duration: exactly Depth cycles after the first clock edge with `rst_ni` high. `init_done_o` rises on the edge that leaves INIT.
- Reset asserted mid-sweep or mid-read: a pending `rvalid` is discarded, the sweep restarts at address 0, and `ptr` returns to 0.
- A request arriving on the same cycle as the INIT→RUN transition is granted in the first RUN cycle.

## Configuration
- `PRIM_RAM_PORT_ARB_INIT_EN` defined:
  - INIT state, `init_cnt` and the zero sweep are compiled in.
  - `init_done_o` follows the sweep.
- Macro undefined:
  - No INIT logic.
  - The block enters RUN directly after reset; `init_done_o` is constant 1 after reset.
  - RAM contents are uninitialised.

## Test plan
- Macro on, Depth=128: release reset with requests pending. Required response:
  - `gnt_o`=0 for 128 cycles, with writes of 0 at addresses 0..127.
  - `init_done_o` rises on cycle 128, then the pending request is granted.
  - Afterwards, every read returns 0.
- NumReq=4, all requests held continuously, no writes: grants go 0,1,2,3,0,… one per cycle, each read's `rvalid` arrives the following cycle at the matching index.
- Req 2 writes 0xDEADBEEF at address 5 with mask 0xFFFF0000; req 1 then reads address 5: `rvalid_o[1]` with `rdata_o`=0xDEAD0000 (after init).
- `ptr`=3 with only req 1 asserted: req 1 is granted immediately and `ptr` becomes 2.
- Reset asserted at sweep address 40 and released: the sweep restarts at 0 and `init_done_o` stays low for a further 128 cycles.
- Read granted, reset pulsed before the next edge: no `rvalid_o` is asserted after release.
